// File: rtl/mdu_sched.sv
// mdu_sched: multi-cycle mult/div scheduler that owns HI/LO and raises D-stage stalls.
// Define MDU_CANCEL_EN to add the cancel flush input.
module mdu_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   phi_q, phi_d;
    logic [31:0]   plo_q, plo_d;
    logic          done_q, done_d;
    logic          cancel_w;

`ifdef MDU_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    logic is_mul, is_div, is_mthi, is_mtlo, is_sgn;

    assign is_mul  = (md_op == 3'd1) || (md_op == 3'd2);
    assign is_div  = (md_op == 3'd3) || (md_op == 3'd4);
    assign is_mthi = (md_op == 3'd5);
    assign is_mtlo = (md_op == 3'd6);
    assign is_sgn  = (md_op == 3'd1) || (md_op == 3'd3);

    // Sign-extended operands let one 64-bit multiplier serve mult and multu.
    logic [63:0] ext_a, ext_b, prod;

    assign ext_a = {{32{is_sgn & rs_val[31]}}, rs_val};
    assign ext_b = {{32{is_sgn & rt_val[31]}}, rt_val};
    assign prod  = ext_a * ext_b;

    logic        a_neg, b_neg, div0;
    logic [31:0] mag_a, mag_b, dvs;
    logic [31:0] quo_m, rem_m, quo, rem;

    assign a_neg = is_sgn & rs_val[31];
    assign b_neg = is_sgn & rt_val[31];
    assign mag_a = a_neg ? -rs_val : rs_val;
    assign mag_b = b_neg ? -rt_val : rt_val;
    assign div0  = (rt_val == 32'd0);
    assign dvs   = div0 ? 32'd1 : mag_b;
    assign quo_m = mag_a / dvs;
    assign rem_m = mag_a % dvs;
    assign quo   = (a_neg ^ b_neg) ? -quo_m : quo_m;
    assign rem   = a_neg ? -rem_m : rem_m;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !cancel_w) begin
                    unique case (1'b1)
                        is_mul: begin
                            phi_d   = prod[63:32];
                            plo_d   = prod[31:0];
                            count_d = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        is_div: begin
                            // A zero divisor completes by rewriting the current HI/LO.
                            phi_d   = div0 ? hi_q : rem;
                            plo_d   = div0 ? lo_q : quo;
                            count_d = CW'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        is_mthi: hi_d = rs_val;
                        is_mtlo: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cancel_w) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        hi_d    = phi_q;
                        lo_d    = plo_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign stall = d_is_md & (busy | (start & (is_mul | is_div)));
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: scoreboard bench for mdu_sched with a queue-based result monitor.
// Directed corner cases followed by randomized operations.
module tb_mdu_sched;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        d_is_md = 1'b0;
`ifdef MDU_CANCEL_EN
    logic        cancel = 1'b0;
`endif
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    mdu_sched #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .d_is_md(d_is_md),
`ifdef MDU_CANCEL_EN
        .cancel (cancel),
`endif
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          n_pass = 0;
    int          n_chk = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    endtask

    // Reference arithmetic straight from the ISA rules.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, b,
                                  input logic [31:0] ch, cl,
                                  output logic [31:0] rh, rl);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        rh = ch;
        rl = cl;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd1: begin
                sp = longint'(sa) * longint'(sb);
                rh = sp[63:32];
                rl = sp[31:0];
            end
            3'd2: begin
                up = {32'd0, a} * {32'd0, b};
                rh = up[63:32];
                rl = up[31:0];
            end
            3'd3: begin
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
                        rh = 32'd0;
                        rl = 32'h8000_0000;
                    end else begin
                        rl = 32'(sa / sb);
                        rh = 32'(sa % sb);
                    end
                end
            end
            3'd4: begin
                if (b != 32'd0) begin
                    rl = a / b;
                    rh = a % b;
                end
            end
            3'd5: rh = a;
            3'd6: rl = a;
            default: ;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (exp_q.size() == 0) begin
                chk1("done_expected", 1'b0, 1'b1);
            end else begin
                e = exp_q.pop_front();
                chk32("result_hi", hi, e.hi);
                chk32("result_lo", lo, e.lo);
            end
        end
    end

    // Entered and left at a falling edge. mode: 0 plain, 1 mtlo while busy,
    // 2 reset at 3rd busy cycle, 3 cancel at 4th busy cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, b,
                          input logic dmd, input int mode);
        logic [31:0] eh, el, oh, ol;
        int          lat, nb;
        lat = (op == 3'd1 || op == 3'd2) ? MULT_N : DIV_N;
        oh = m_hi;
        ol = m_lo;
        model(op, a, b, m_hi, m_lo, eh, el);
        start = 1'b1;
        md_op = op;
        rs_val = a;
        rt_val = b;
        d_is_md = dmd;
        #1;
        chk1("stall_on_start", stall, dmd);
        chk1("busy_before", busy, 1'b0);
        exp_q.push_back('{eh, el});
        m_hi = eh;
        m_lo = el;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        nb = 0;
        while (!done && nb < 40) begin
            nb++;
            chk1("busy_run", busy, 1'b1);
            chk1("stall_run", stall, dmd);
            chk32("hi_old", hi, oh);
            chk32("lo_old", lo, ol);
            if (mode == 2 && nb == 3) begin
                reset = 1'b0;
                #1;
                chk1("abort_busy", busy, 1'b0);
                chk1("abort_done", done, 1'b0);
                chk1("abort_stall", stall, 1'b0);
                chk32("abort_hi", hi, 32'd0);
                chk32("abort_lo", lo, 32'd0);
                exp_q.delete(exp_q.size() - 1);
                m_hi = 32'd0;
                m_lo = 32'd0;
                #1 reset = 1'b1;
                d_is_md = 1'b0;
                @(negedge clk);
                return;
            end
`ifdef MDU_CANCEL_EN
            if (mode == 3 && nb == 4) begin
                cancel = 1'b1;
                @(negedge clk);
                cancel = 1'b0;
                chk1("cancel_busy", busy, 1'b0);
                chk1("cancel_done", done, 1'b0);
                chk32("cancel_hi", hi, oh);
                chk32("cancel_lo", lo, ol);
                exp_q.delete(exp_q.size() - 1);
                m_hi = oh;
                m_lo = ol;
                d_is_md = 1'b0;
                return;
            end
`endif
            start = (mode == 1 && nb == 2);
            md_op = start ? 3'd6 : 3'd0;
            rs_val = $urandom;
            @(negedge clk);
        end
        if (nb >= 40) chk1("done_timeout", 1'b0, 1'b1);
        chk32("busy_cycles", 32'(nb), 32'(lat));
        chk1("busy_at_done", busy, 1'b0);
        chk1("stall_at_done", stall, 1'b0);
        d_is_md = 1'b0;
    endtask

    // Non-running ops (none, mthi, mtlo, reserved); entered and left at a falling edge.
    task automatic run_simple(input logic [2:0] op, input logic [31:0] a);
        logic [31:0] eh, el;
        model(op, a, 32'd0, m_hi, m_lo, eh, el);
        start = 1'b1;
        md_op = op;
        rs_val = a;
        d_is_md = 1'b1;
        #1;
        chk1("stall_simple", stall, 1'b0);
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        d_is_md = 1'b0;
        m_hi = eh;
        m_lo = el;
        chk1("busy_simple", busy, 1'b0);
        chk1("done_simple", done, 1'b0);
        chk32("hi_simple", hi, m_hi);
        chk32("lo_simple", lo, m_lo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          sel;
        #2;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk32("rst_hi", hi, 32'd0);
        chk32("rst_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_op(3'd1, 32'hffff_fffe, 32'd3, 1'b1, 0);
        chk32("mult_hi", hi, 32'hffff_ffff);
        chk32("mult_lo", lo, 32'hffff_fffa);
        run_op(3'd2, 32'hffff_ffff, 32'hffff_ffff, 1'b1, 1);
        chk32("multu_hi", hi, 32'hffff_fffe);
        chk32("multu_lo", lo, 32'h0000_0001);
        run_op(3'd3, 32'hffff_fff9, 32'd2, 1'b1, 0);
        chk32("div_hi", hi, 32'hffff_ffff);
        chk32("div_lo", lo, 32'hffff_fffd);
        run_op(3'd4, 32'd1234, 32'd0, 1'b0, 0);
        chk32("divu0_hi", hi, 32'hffff_ffff);
        chk32("divu0_lo", lo, 32'hffff_fffd);
        run_simple(3'd5, 32'h1234_5678);
        chk32("mthi_hi", hi, 32'h1234_5678);
        run_simple(3'd6, 32'hcafe_f00d);
        run_op(3'd3, 32'h8000_0000, 32'hffff_ffff, 1'b1, 0);
        chk32("ovf_hi", hi, 32'd0);
        chk32("ovf_lo", lo, 32'h8000_0000);
        run_op(3'd3, 32'd100, 32'd7, 1'b1, 2);
        run_op(3'd4, 32'd100, 32'd7, 1'b1, 0);
        chk32("divu_lo", lo, 32'd14);
        chk32("divu_hi", hi, 32'd2);
`ifdef MDU_CANCEL_EN
        run_op(3'd3, 32'd555, 32'd5, 1'b1, 3);
        start = 1'b1;
        md_op = 3'd1;
        rs_val = 32'd9;
        rt_val = 32'd9;
        cancel = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b0;
        chk1("cancel_idle_busy", busy, 1'b0);
        chk32("cancel_idle_lo", lo, m_lo);
`endif
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 5);
            a = $urandom;
            b = $urandom;
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hffff_ffff;
            end
            if (sel == 2) b = 32'($urandom_range(1, 9));
            if (op >= 3'd1 && op <= 3'd4)
                run_op(op, a, b, 1'($urandom_range(0, 1)), (sel == 3) ? 1 : 0);
            else
                run_simple(op, a);
        end
        repeat (2) @(negedge clk);
        chk32("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
